// File: rtl/ama_riscv_rf_dump.sv
// ---------------------------------------------------------------------------
// ama_riscv_rf_dump
//
// Purpose: streams the 32 integer registers x0..x31 of a RISC-V core out over
// a valid/ready port. Registers are read in pairs through the two register
// file read ports. While a dump is running the core is asked to hold its
// register writes (rf_stall), so every pair is a consistent snapshot.
//
// Parameters:
//   SKIP_X0    1 = do not emit the hard-wired x0 word (dump starts at x1)
//
// Ports:
//   clk        single clock, rising-edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle dump request, honoured only when idle
//   abort      synchronous cancel of a running dump
//   rf_addr_a  register file port A address (even register of the pair)
//   rf_addr_b  register file port B address (odd register of the pair)
//   rf_data_a  register file port A data, combinational from rf_addr_a
//   rf_data_b  register file port B data, combinational from rf_addr_b
//   rf_stall   hold core register writes; mirrors busy
//   out_valid  out_data/out_addr/out_last carry a word
//   out_ready  consumer accepts the current word
//   out_data   register value
//   out_addr   register index of out_data
//   out_last   current word is x31
//   busy       dump in progress
//   done       one-cycle pulse after x31 has been accepted
// ---------------------------------------------------------------------------
module ama_riscv_rf_dump #(
  parameter bit SKIP_X0 = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  output logic [4:0]  rf_addr_a,
  output logic [4:0]  rf_addr_b,
  input  logic [31:0] rf_data_a,
  input  logic [31:0] rf_data_b,
  output logic        rf_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_addr,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND_A = 2'd2,
    SEND_B = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [31:0] buf_a_q, buf_a_d;
  logic [31:0] buf_b_q, buf_b_d;
  logic [4:0]  rf_addr_a_q, rf_addr_a_d;
  logic [4:0]  rf_addr_b_q, rf_addr_b_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_addr_q, out_addr_d;
  logic        out_last_q, out_last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here are what the outputs show in the following cycle.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    buf_a_d     = buf_a_q;
    buf_b_d     = buf_b_q;
    rf_addr_a_d = rf_addr_a_q;
    rf_addr_b_d = rf_addr_b_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = FETCH;
          k_d         = 4'd0;
          // Addresses are registered, so the pair is presented on entry to
          // FETCH and the combinational read data is ready within FETCH.
          rf_addr_a_d = 5'd0;
          rf_addr_b_d = 5'd1;
        end
      end

      FETCH: begin
        buf_a_d     = rf_data_a;
        buf_b_d     = rf_data_b;
        out_valid_d = 1'b1;
        if (SKIP_X0 && (k_q == 4'd0)) begin
          // x0 is hard-wired to zero; go straight to its partner x1.
          state_d    = SEND_B;
          out_data_d = rf_data_b;
          out_addr_d = rf_addr_b_q;
        end else begin
          state_d    = SEND_A;
          out_data_d = rf_data_a;
          out_addr_d = rf_addr_a_q;
        end
      end

      SEND_A: begin
        out_valid_d = 1'b1;
        if (out_ready) begin
          state_d    = SEND_B;
          out_data_d = buf_b_q;
          out_addr_d = {k_q, 1'b1};
          out_last_d = (k_q == 4'd15);
        end else begin
          out_last_d = out_last_q;
        end
      end

      SEND_B: begin
        if (out_ready) begin
          if (k_q == 4'd15) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d     = FETCH;
            k_d         = k_q + 4'd1;
            rf_addr_a_d = {k_q + 4'd1, 1'b0};
            rf_addr_b_d = {k_q + 4'd1, 1'b1};
          end
        end else begin
          out_valid_d = 1'b1;
          out_last_d  = out_last_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides everything above. A word accepted in the same cycle
    // still counts as transferred; the dump simply ends without done, and
    // the read addresses are not advanced to a pair that will never be read.
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      k_d         = k_q;
      rf_addr_a_d = rf_addr_a_q;
      rf_addr_b_d = rf_addr_b_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= 4'd0;
      buf_a_q     <= 32'd0;
      buf_b_q     <= 32'd0;
      rf_addr_a_q <= 5'd0;
      rf_addr_b_q <= 5'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_addr_q  <= 5'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      buf_a_q     <= buf_a_d;
      buf_b_q     <= buf_b_d;
      rf_addr_a_q <= rf_addr_a_d;
      rf_addr_b_q <= rf_addr_b_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign rf_addr_a = rf_addr_a_q;
  assign rf_addr_b = rf_addr_b_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign rf_stall  = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ama_riscv_rf_dump.sv
// ---------------------------------------------------------------------------
// tb_ama_riscv_rf_dump
//
// Two instances run side by side on shared control inputs: u_dut with
// SKIP_X0=0 (index 0) and u_dut with SKIP_X0=1 (index 1). Each has its own
// view of a shared register file array. A word-level model predicts, per
// instance, which register must be on the output port in every cycle.
// ---------------------------------------------------------------------------
module tb_ama_riscv_rf_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n     = 1'b1;
  logic start     = 1'b0;
  logic abort     = 1'b0;
  logic out_ready = 1'b1;

  logic [31:0] regs [32];

  logic [4:0]  ra_a [2];
  logic [4:0]  ra_b [2];
  logic [31:0] rd_a [2];
  logic [31:0] rd_b [2];
  logic        st   [2];
  logic        ov   [2];
  logic [31:0] od   [2];
  logic [4:0]  oa   [2];
  logic        ol   [2];
  logic        bz   [2];
  logic        dn   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ama_riscv_rf_dump #(.SKIP_X0(g == 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .rf_addr_a (ra_a[g]),
      .rf_addr_b (ra_b[g]),
      .rf_data_a (rd_a[g]),
      .rf_data_b (rd_b[g]),
      .rf_stall  (st[g]),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_data  (od[g]),
      .out_addr  (oa[g]),
      .out_last  (ol[g]),
      .busy      (bz[g]),
      .done      (dn[g])
    );
    assign rd_a[g] = regs[ra_a[g]];
    assign rd_b[g] = regs[ra_b[g]];
  end

  // Shared between stimulus and checker (each variable has one writer).
  bit preload = 1'b0;   // regs hold 0xA5A50000+N and out_ready is held 1
  bit end_req = 1'b0;
  int tmo_cnt = 0;

  // ---------------- reference model + compare ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit          m_act   [2];  // a dump is running
  bit          m_gap   [2];  // current cycle is a read bubble (no word shown)
  bit          m_done  [2];  // done pulse expected this cycle
  int          m_next  [2];  // register index that must be shown next
  int          m_start [2];  // cycle in which start was presented
  int          m_words [2];  // words accepted in this dump
  bit          p_stall [2];
  logic [31:0] p_data  [2];
  logic [4:0]  p_addr  [2];
  bit          xfer;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_gap[i] = 0; m_done[i] = 0; m_next[i] = 0;
      m_start[i] = 0; m_words[i] = 0; p_stall[i] = 0;
      p_data[i] = '0; p_addr[i] = '0;
    end
  end

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got 0x%0h expected 0x%0h",
               name, inst, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("rst_valid", i, 32'(ov[i]), 32'd0);
        chk("rst_last",  i, 32'(ol[i]), 32'd0);
        chk("rst_busy",  i, 32'(bz[i]), 32'd0);
        chk("rst_stall", i, 32'(st[i]), 32'd0);
        chk("rst_done",  i, 32'(dn[i]), 32'd0);
        chk("rst_addr_a", i, 32'(ra_a[i]), 32'd0);
        chk("rst_addr_b", i, 32'(ra_b[i]), 32'd0);
        m_act[i] = 0; m_gap[i] = 0; m_done[i] = 0; p_stall[i] = 0;
      end else begin
        chk("busy",  i, 32'(bz[i]), 32'(m_act[i]));
        chk("stall", i, 32'(st[i]), 32'(m_act[i]));
        chk("valid", i, 32'(ov[i]), 32'(m_act[i] && !m_gap[i]));
        chk("done",  i, 32'(dn[i]), 32'(m_done[i]));
        if (m_act[i] && !m_gap[i]) begin
          chk("addr", i, 32'(oa[i]), 32'(m_next[i]));
          chk("data", i, od[i], regs[m_next[i][4:0]]);
          chk("last", i, 32'(ol[i]), 32'(m_next[i] == 31));
          if (p_stall[i]) begin
            chk("hold_data", i, od[i], p_data[i]);
            chk("hold_addr", i, 32'(oa[i]), 32'(p_addr[i]));
          end
        end
        if (m_act[i] && m_gap[i]) begin
          chk("fetch_addr_a", i, 32'(ra_a[i]), 32'(m_next[i] & ~1));
          chk("fetch_addr_b", i, 32'(ra_b[i]), 32'(m_next[i] | 1));
        end
        if (m_done[i] && preload) begin
          // Edges from the one sampling start to the one raising done.
          chk("start_to_done", i, 32'(cyc - m_start[i] - 1), (i == 1) ? 32'd47 : 32'd48);
          chk("word_count", i, 32'(m_words[i]), (i == 1) ? 32'd31 : 32'd32);
        end

        // Advance the model with the inputs the next edge will sample.
        xfer       = m_act[i] && !m_gap[i] && out_ready;
        p_stall[i] = m_act[i] && !m_gap[i] && !out_ready;
        p_data[i]  = od[i];
        p_addr[i]  = oa[i];
        if (xfer && preload && m_words[i] == 0)
          chk("first_word", i, od[i], (i == 1) ? 32'hA5A5_0001 : 32'hA5A5_0000);
        if (xfer) m_words[i]++;
        m_done[i] = 0;
        if (m_act[i]) begin
          if (abort) begin
            m_act[i] = 0;
          end else if (m_gap[i]) begin
            m_gap[i] = 0;
          end else if (out_ready) begin
            if (m_next[i] == 31) begin
              m_act[i]  = 0;
              m_done[i] = 1;
            end else begin
              if (m_next[i] % 2 == 1) m_gap[i] = 1;
              m_next[i]++;
            end
          end
        end else if (start && !abort) begin
          m_act[i]   = 1;
          m_gap[i]   = 1;
          m_next[i]  = i;
          m_start[i] = cyc;
          m_words[i] = 0;
        end
      end
    end
    if (end_req) begin
      chk("wait_timeouts", 0, 32'(tmo_cnt), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((bz[0] || bz[1]) && n < maxc) begin
      tick();
      n++;
    end
    if (bz[0] || bz[1]) tmo_cnt++;
  endtask

  task automatic wait_addr(input int a, input int maxc);
    int n = 0;
    while (!(ov[0] && oa[0] == a[4:0]) && n < maxc) begin
      tick();
      n++;
    end
    if (!(ov[0] && oa[0] == a[4:0])) tmo_cnt++;
  endtask

  task automatic load_pattern();
    for (int r = 0; r < 32; r++) regs[r] = 32'hA5A5_0000 + 32'(r);
  endtask

  task automatic load_random();
    for (int r = 0; r < 32; r++) regs[r] = $urandom;
  endtask

  initial begin
    load_pattern();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Full dump, consumer always ready.
    preload = 1'b1;
    pulse_start();
    wait_idle(200);
    tick();
    preload = 1'b0;

    // start together with abort while idle must not start a dump.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (3) tick();

    // Random back-pressure, with stray start pulses while busy.
    for (int d = 0; d < 3; d++) begin
      int n;
      load_random();
      pulse_start();
      n = 0;
      while ((bz[0] || bz[1]) && n < 600) begin
        out_ready = ($urandom_range(0, 3) != 0);
        start     = (bz[0] && bz[1] && $urandom_range(0, 15) == 0);
        tick();
        n++;
      end
      start     = 1'b0;
      out_ready = 1'b1;
      if (bz[0] || bz[1]) tmo_cnt++;
      tick();
    end

    // Abort while x9 is stalled, then a clean dump.
    load_random();
    out_ready = 1'b1;
    pulse_start();
    wait_addr(9, 200);
    out_ready = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    wait_idle(10);
    tick();
    pulse_start();
    wait_idle(200);
    tick();

    // Abort coinciding with an accepted word.
    pulse_start();
    wait_addr(20, 200);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_idle(10);
    tick();

    // Asynchronous reset mid-cycle while x15 (second word of pair 7) is shown.
    load_pattern();
    pulse_start();
    wait_addr(15, 200);
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Clean dump after reset, with a start pulse ignored mid-dump.
    preload = 1'b1;
    pulse_start();
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle(200);
    tick();
    preload = 1'b0;

    end_req = 1'b1;
    repeat (5) tick();
    $display("FAIL end_of_test: checker did not close the run");
    $fatal(1);
  end

endmodule

// File: doc/ama_riscv_rf_dump.md
AMA_RISCV_RF_DUMP -- requirements
Module: ama_riscv_rf_dump

Interface
REQ-001 SHALL have parameter SKIP_X0, default 0; when 1, the x0 word is not emitted.
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have start  input  1  one-cycle request to dump x0..x31.
REQ-005 SHALL have abort  input  1  synchronous cancel of a dump in progress.
REQ-006 SHALL have rf_addr_a  output  5  register file read port A address.
REQ-007 SHALL have rf_addr_b  output  5  register file read port B address.
REQ-008 SHALL have rf_data_a  input  32  register file port A data, combinational from rf_addr_a.
REQ-009 SHALL have rf_data_b  input  32  register file port B data, combinational from rf_addr_b.
REQ-010 SHALL have rf_stall  output  1  request to hold core register writes; equals busy.
REQ-011 SHALL have out_valid  output  1  out_data/out_addr/out_last are valid.
REQ-012 SHALL have out_ready  input  1  consumer accepts the current word.
REQ-013 SHALL have out_data  output  32  register value.
REQ-014 SHALL have out_addr  output  5  register index of out_data.
REQ-015 SHALL have out_last  output  1  current word is x31.
REQ-016 SHALL have busy  output  1  FSM not in IDLE.
REQ-017 SHALL have done  output  1  one-cycle pulse after x31 is accepted.

Function
REQ-018 SHALL implement states IDLE, FETCH, SEND_A, SEND_B, plus a 4-bit pair counter k (0..15).
REQ-019 IDLE: start=1 and abort=0 SHALL set k=0 and go to FETCH; otherwise stay in IDLE.
REQ-020 FETCH SHALL drive rf_addr_a=2k and rf_addr_b=2k+1, capture rf_data_a/rf_data_b into buf_a/buf_b at the clock edge, and go to SEND_A.
REQ-021 Exception to REQ-020: in FETCH with k=0 and SKIP_X0=1, the next state SHALL be SEND_B.
REQ-022 Outside FETCH, rf_addr_a and rf_addr_b SHALL hold their last driven values.
REQ-023 SEND_A SHALL drive out_valid=1, out_data=buf_a, out_addr=2k and out_last=0; it SHALL go to SEND_B only in a cycle where out_ready=1.
REQ-024 SEND_B SHALL drive out_valid=1, out_data=buf_b and out_addr=2k+1, with out_last=1 when k=15.
REQ-025 SEND_B on out_ready=1 with k<15 SHALL increment k and go to FETCH.
REQ-026 SEND_B on out_ready=1 with k=15 SHALL go to IDLE and assert done for exactly the next cycle.
REQ-027 out_valid SHALL be 0 in IDLE and FETCH.
REQ-028 While out_valid=1 and out_ready=0, out_data, out_addr and out_last SHALL remain stable.
REQ-029 Latency: start sampled at edge n SHALL produce out_valid=1 from cycle n+2 (FETCH occupies cycle n+1).
REQ-030 Full dump with out_ready held 1 SHALL take 48 cycles from start to done (16 FETCH + 32 SEND); with SKIP_X0=1 it SHALL take 47.
REQ-031 Each FETCH after a pair introduces exactly one bubble cycle with out_valid=0.
REQ-032 start while busy=1 SHALL be ignored.
REQ-033 abort=1 in any non-IDLE state SHALL return the FSM to IDLE at the next edge, with no done pulse and out_valid=0 from that cycle.
REQ-034 abort=1 and start=1 together in IDLE SHALL leave the FSM in IDLE.
REQ-035 abort=1 coinciding with an out_valid/out_ready transfer SHALL count that word as transferred, and the dump SHALL still end without done.
REQ-036 k SHALL NOT wrap; the counter never exceeds 15.
REQ-037 busy and rf_stall SHALL be 1 in FETCH, SEND_A and SEND_B, and 0 in IDLE.

Reset
REQ-038 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, k=0, buf_a=buf_b=0, rf_addr_a=rf_addr_b=0, and out_valid=out_last=busy=done=rf_stall=0.
REQ-039 rst_n asserted mid-dump SHALL abandon the dump with no done pulse; after release, the block SHALL wait in IDLE for a new start.
REQ-040 Deassertion of rst_n SHALL be the only exit from reset; the first start is honoured on the first edge after release.

Verification
REQ-041 Reg model preloaded with xN=0xA5A50000+N, out_ready=1, pulse start -> 32 words addr 0..31 in order; data matches the model; out_last only on addr 31; done one cycle later; 48 cycles start-to-done.
REQ-042 SKIP_X0=1, same stimulus -> first word addr 1 data 0xA5A50001; 31 words total; done 47 cycles after start.
REQ-043 out_ready toggled pseudo-randomly -> no word lost or duplicated; out_data/out_addr stable while stalled; busy=rf_stall=1 throughout.
REQ-044 abort pulsed while out_addr=9 is stalled -> busy=0 and out_valid=0 next cycle, no done; a following start gives a clean dump from addr 0.
REQ-045 rst_n pulled low asynchronously mid-cycle during SEND_B at k=7 -> all outputs 0 before the next edge; start pulsed during busy -> ignored, sequence unaffected.
